// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized CNN frame sequencer.
//   seq_state_t     : sequencer FSM states
//   CONV1_CYCLES    : conv1 engine latency, 12x12 output sweep plus its done register
//   DEFAULT_TIMEOUT : default per-stage watchdog limit in cycles
package bnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LAUNCH,
    WAIT,
    OUT,
    ERR
  } seq_state_t;

  localparam int CONV1_CYCLES    = 145;
  localparam int DEFAULT_TIMEOUT = 511;

endpackage

// File: rtl/bnn_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : synchronous, active-high, forces the count to 0
//   clr   : synchronous clear to 0 (takes priority over en)
//   en    : count up by one when not already saturated
//   cnt   : current count
module bnn_sat_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Frame-level controller for the binarized CNN datapath.
// Accepts one frame per img_valid/img_ready handshake, pulses img_latch, then
// launches each layer engine in turn with a one-cycle stage_begin pulse and
// waits for that engine's stage_done. After the last stage the result is
// offered on res_valid until res_ready. A per-stage watchdog traps hung engines
// into a sticky error state that only err_clear (or reset) leaves.
//   clk, reset    : clock, synchronous active-high reset
//   img_valid/img_ready : frame input handshake
//   img_latch     : one-cycle pulse, datapath captures the input image
//   stage_begin   : one-hot begin pulse per engine
//   stage_done    : done pulse per engine (only the active stage is observed)
//   res_valid/res_ready : result handshake
//   busy          : any state other than IDLE
//   cur_stage     : index of the active stage
//   error         : sticky watchdog error, err_clear releases it
//   frame_cnt     : completed frames, wraps
//   last_latency  : LATCH-to-result-accept cycles of the last frame, saturating
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter  int NUM_STAGES = 3,
  parameter  int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter  int TMR_W      = 10,
  parameter  int FRM_W      = 16,
  localparam int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  img_valid,
  output logic                  img_ready,
  output logic                  img_latch,
  output logic [NUM_STAGES-1:0] stage_begin,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic [SW-1:0]         cur_stage,
  output logic                  error,
  input  logic                  err_clear,
  output logic [FRM_W-1:0]      frame_cnt,
  output logic [TMR_W-1:0]      last_latency
);

  seq_state_t      state, nxt_state;
  logic [SW-1:0]   stage, nxt_stage;
  logic            done_cur;
  logic [TMR_W-1:0] wdt_cnt;
  logic [TMR_W-1:0] lat_cnt;

  // Latency includes the accept cycle itself, so the stored value is one past
  // the running count, still capped at all-ones.
  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == '1) ? v : v + TMR_W'(1);
  endfunction

  // Watchdog reads 0 in the LAUNCH cycle and k in the k-th cycle after the
  // begin pulse, so a timeout at TIMEOUT lands error TIMEOUT+1 cycles after begin.
  bnn_sat_counter #(.W(TMR_W)) u_wdt (
    .clk   (clk),
    .reset (reset),
    .clr   (nxt_state == LAUNCH),
    .en    ((state == LAUNCH) || (state == WAIT)),
    .cnt   (wdt_cnt)
  );

  bnn_sat_counter #(.W(TMR_W)) u_lat (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE),
    .en    ((state != IDLE) && (state != ERR)),
    .cnt   (lat_cnt)
  );

  always_comb begin
    nxt_state = state;
    nxt_stage = stage;
    // Only the active stage's done is observed; strays from other engines are dropped.
    done_cur  = stage_done[stage];
    case (state)
      IDLE: begin
        nxt_stage = '0;
        if (img_valid && img_ready) nxt_state = LATCH;
      end
      LATCH:  nxt_state = LAUNCH;
      LAUNCH: nxt_state = WAIT;
      WAIT: begin
        // done is checked first so it wins over a coincident timeout
        if (done_cur) begin
          if (stage == SW'(NUM_STAGES - 1)) begin
            nxt_state = OUT;
          end else begin
            nxt_stage = stage + SW'(1);
            nxt_state = LAUNCH;
          end
        end else if (wdt_cnt == TMR_W'(TIMEOUT)) begin
          nxt_state = ERR;
        end
      end
      OUT: if (res_ready) nxt_state = IDLE;
      ERR: begin
        if (err_clear) begin
          nxt_state = IDLE;
          nxt_stage = '0;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      stage        <= '0;
      img_ready    <= 1'b1;
      img_latch    <= 1'b0;
      stage_begin  <= '0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      frame_cnt    <= '0;
      last_latency <= '0;
    end else begin
      state       <= nxt_state;
      stage       <= nxt_stage;
      img_ready   <= (nxt_state == IDLE);
      img_latch   <= (nxt_state == LATCH);
      stage_begin <= (nxt_state == LAUNCH) ? (NUM_STAGES'(1) << nxt_stage) : '0;
      res_valid   <= (nxt_state == OUT);
      busy        <= (nxt_state != IDLE);
      error       <= (nxt_state == ERR);
      if ((state == OUT) && res_ready) begin
        frame_cnt    <= frame_cnt + FRM_W'(1);
        last_latency <= sat_inc(lat_cnt);
      end
    end
  end

  assign cur_stage = stage;

endmodule
